serial_host_master: RTL and testbench

- Host-side master that generates the single-wire frame stream consumed by serial_ctrl.
- Accepts one parallel request per transaction over a valid/ready handshake: a command, plus write data for START_RCV.
- Serializes start bit, command, and (for START_RCV) data onto the line; for START_SND it turns the line around and deserializes the DATA_LEN-bit readback.
- Sits between the host/register logic and the top-level tristate pad that drives serial_ctrl.data_inout.

---
 rtl/serial_host_master.sv | 185 ++++++++++++++++++
 tb/tb_serial_host_master.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_host_master.sv
// Host-side master for the single-wire serial_ctrl link: serializes a start bit,
// command and optional write data, and for read commands turns the line around
// and deserializes the returned word. All outputs are registered from the
// next-state decode so they change on the same edge as the state.
module serial_host_master #(
    parameter int unsigned          CMD_LEN  = 3,
    parameter int unsigned          DATA_LEN = 8,
    parameter logic [CMD_LEN-1:0]   CMD_RCV  = 3'b001,
    parameter logic [CMD_LEN-1:0]   CMD_SND  = 3'b010,
    parameter int unsigned          RCV_GAP  = 1,
    parameter int unsigned          SND_GAP  = 2,
    parameter int unsigned          IDLE_GAP = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CMD_LEN-1:0]  req_cmd,
    input  logic [DATA_LEN-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [DATA_LEN-1:0] rsp_rdata,
    output logic                busy,
    output logic                ser_out,
    output logic                ser_oe,
    input  logic                ser_in
);

    localparam int unsigned MAX_A   = (CMD_LEN > DATA_LEN) ? CMD_LEN : DATA_LEN;
    localparam int unsigned MAX_B   = (RCV_GAP > SND_GAP) ? RCV_GAP : SND_GAP;
    localparam int unsigned MAX_C   = (MAX_B > IDLE_GAP) ? MAX_B : IDLE_GAP;
    localparam int unsigned MAX_LEN = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // Counter load values: each state counts from length-1 down to 0
    localparam logic [CNT_W-1:0] CMD_CNT  = CNT_W'(CMD_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_LEN - 1);
    localparam logic [CNT_W-1:0] RCV_CNT  = CNT_W'((RCV_GAP > 0) ? RCV_GAP - 1 : 0);
    localparam logic [CNT_W-1:0] SND_CNT  = CNT_W'((SND_GAP > 0) ? SND_GAP - 1 : 0);
    localparam logic [CNT_W-1:0] TAIL_CNT = CNT_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    typedef enum logic [3:0] {
        IDLE, START, CMD, STOP, WGAP, WDATA, WSTOP,
        SGAP, TURN, SAMPLE, RELEASE, TAIL
    } state_t;

    state_t              state_q, state_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic [CMD_LEN-1:0]  cmd_q;
    logic [DATA_LEN-1:0] wdata_q;
    logic [DATA_LEN-1:0] shift_q, shift_nxt;

    logic                req_ready_c, busy_c, rsp_valid_c, ser_out_c, ser_oe_c;
    logic [DATA_LEN-1:0] rsp_rdata_c;

    // State, counter, latched request, sample shifter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            wdata_q   <= '0;
            shift_q   <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ser_out   <= 1'b0;
            ser_oe    <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            shift_q   <= shift_nxt;
            if (state_q == IDLE && req_valid && req_ready) begin
                cmd_q   <= req_cmd;
                wdata_q <= req_wdata;
            end
            req_ready <= req_ready_c;
            busy      <= busy_c;
            rsp_valid <= rsp_valid_c;
            rsp_rdata <= rsp_rdata_c;
            ser_out   <= ser_out_c;
            ser_oe    <= ser_oe_c;
        end
    end

    // Frame sequencing; zero-length gaps skip their state entirely
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        shift_nxt = shift_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) state_nxt = START;
            end
            START: begin
                state_nxt = CMD;
                cnt_nxt   = CMD_CNT;
            end
            CMD: begin
                if (cnt_q == '0) state_nxt = STOP;
                else             cnt_nxt   = cnt_q - CNT_W'(1);
            end
            STOP: begin
                if (cmd_q == CMD_RCV) begin
                    if (RCV_GAP != 0) begin
                        state_nxt = WGAP;
                        cnt_nxt   = RCV_CNT;
                    end else begin
                        state_nxt = WDATA;
                        cnt_nxt   = DATA_CNT;
                    end
                end else if (cmd_q == CMD_SND) begin
                    if (SND_GAP != 0) begin
                        state_nxt = SGAP;
                        cnt_nxt   = SND_CNT;
                    end else begin
                        state_nxt = TURN;
                    end
                end else begin
                    state_nxt = (IDLE_GAP != 0) ? TAIL : IDLE;
                    cnt_nxt   = TAIL_CNT;
                end
            end
            WGAP: begin
                if (cnt_q == '0) begin
                    state_nxt = WDATA;
                    cnt_nxt   = DATA_CNT;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            WDATA: begin
                if (cnt_q == '0) state_nxt = WSTOP;
                else             cnt_nxt   = cnt_q - CNT_W'(1);
            end
            WSTOP, RELEASE: begin
                state_nxt = (IDLE_GAP != 0) ? TAIL : IDLE;
                cnt_nxt   = TAIL_CNT;
            end
            SGAP: begin
                if (cnt_q == '0) state_nxt = TURN;
                else             cnt_nxt   = cnt_q - CNT_W'(1);
            end
            TURN: begin
                state_nxt = SAMPLE;
                cnt_nxt   = DATA_CNT;
            end
            SAMPLE: begin
                shift_nxt = {shift_q[DATA_LEN-2:0], ser_in};
                if (cnt_q == '0) state_nxt = RELEASE;
                else             cnt_nxt   = cnt_q - CNT_W'(1);
            end
            TAIL: begin
                if (cnt_q == '0) state_nxt = IDLE;
                else             cnt_nxt   = cnt_q - CNT_W'(1);
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode of the upcoming state, registered on the same edge
    always_comb begin
        req_ready_c = (state_nxt == IDLE);
        busy_c      = (state_nxt != IDLE);
        rsp_valid_c = (state_nxt == RELEASE);
        ser_oe_c    = !(state_nxt == TURN || state_nxt == SAMPLE || state_nxt == RELEASE);
        rsp_rdata_c = (state_nxt == RELEASE) ? shift_nxt : rsp_rdata;
        ser_out_c   = 1'b0;
        if (state_nxt == START) begin
            ser_out_c = 1'b1;
        end else if (state_nxt == CMD) begin
            for (int unsigned i = 0; i < CMD_LEN; i++) begin
                if (cnt_nxt == CNT_W'(i)) ser_out_c = cmd_q[i];
            end
        end else if (state_nxt == WDATA) begin
            for (int unsigned i = 0; i < DATA_LEN; i++) begin
                if (cnt_nxt == CNT_W'(i)) ser_out_c = wdata_q[i];
            end
        end
    end

endmodule

// File: tb/tb_serial_host_master.sv
// Self-checking bench for serial_host_master with a small line-side slave that
// stores written words and returns them on read frames.
module tb_serial_host_master;

    localparam logic [2:0] CMD_RCV = 3'b001;
    localparam logic [2:0] CMD_SND = 3'b010;
    localparam logic [2:0] CMD_UPD = 3'b100;
    localparam logic [2:0] CMD_RST = 3'b111;
    localparam int RCV_GAP  = 1;
    localparam int SND_GAP  = 2;
    localparam int IDLE_GAP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_cmd = 3'b000;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       ser_out;
    logic       ser_oe;
    logic       ser_in = 1'b0;

    serial_host_master dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .ser_out   (ser_out),
        .ser_oe    (ser_oe),
        .ser_in    (ser_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] out;
        logic [63:0] oe;
        int          len;
        int          rsp_cyc;
        logic [7:0]  rdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp_f;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] obs_out, obs_oe;
    int          obs_len, obs_rsp_cnt, obs_rsp_cyc, obs_rdy_low;
    int          obs_oe_low, obs_oe_first, obs_z_bad;
    logic [7:0]  obs_rdata, obs_rdata_end;
    logic        obs_rdy_end;

    // Line-side slave: word returned on read frames
    logic [7:0] slave_reg = 8'h00;
    int         oe_low = 0;

    // Slave drives returned bits MSB first during the sample window
    always @(negedge clk) begin
        if (ser_oe === 1'b0) oe_low = oe_low + 1;
        else                 oe_low = 0;
        if (oe_low >= 2 && oe_low <= 9) ser_in = slave_reg[9 - oe_low];
        else                            ser_in = 1'b0;
    end

    function automatic exp_t build_exp(input logic [2:0] cmd, input logic [7:0] wd,
                                       input logic [7:0] rd);
        exp_t e;
        int   p;
        e.out = '0; e.oe = '0; e.rsp_cyc = -1; e.rdata = rd; p = 0;
        e.out[p] = 1'b1; e.oe[p] = 1'b1; p++;
        for (int i = 2; i >= 0; i--) begin e.out[p] = cmd[i]; e.oe[p] = 1'b1; p++; end
        e.oe[p] = 1'b1; p++;
        if (cmd == CMD_RCV) begin
            for (int i = 0; i < RCV_GAP; i++) begin e.oe[p] = 1'b1; p++; end
            for (int i = 7; i >= 0; i--) begin e.out[p] = wd[i]; e.oe[p] = 1'b1; p++; end
            e.oe[p] = 1'b1; p++;
        end else if (cmd == CMD_SND) begin
            for (int i = 0; i < SND_GAP; i++) begin e.oe[p] = 1'b1; p++; end
            p = p + 1 + 8;
            e.rsp_cyc = p; p++;
        end
        for (int i = 0; i < IDLE_GAP; i++) begin e.oe[p] = 1'b1; p++; end
        e.len = p;
        return e;
    endfunction

    // Issue one request and record the resulting frame cycle by cycle
    task automatic run_frame(input logic [2:0] cmd, input logic [7:0] wd, input bit hold);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            tests_run++; tests_failed++;
            $display("FAIL ready_timeout: req_ready=%b after %0d cycles, expected 1", req_ready, n);
        end
        req_valid = 1'b1; req_cmd = cmd; req_wdata = wd;
        sb_q.push_back(build_exp(cmd, wd, slave_reg));
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        obs_out = '0; obs_oe = '0; obs_len = 0; obs_rsp_cnt = 0; obs_rsp_cyc = -1;
        obs_rdy_low = 0; obs_oe_low = 0; obs_oe_first = -1; obs_z_bad = 0; obs_rdata = 8'h00;
        while (busy === 1'b1 && obs_len < 64) begin
            obs_out[obs_len] = ser_out;
            obs_oe[obs_len]  = ser_oe;
            if (ser_oe === 1'b0) begin
                obs_oe_low++;
                if (obs_oe_first < 0) obs_oe_first = obs_len;
                if (ser_out !== 1'b0) obs_z_bad++;
            end
            if (rsp_valid === 1'b1) begin
                obs_rsp_cnt++; obs_rsp_cyc = obs_len; obs_rdata = rsp_rdata;
            end
            if (req_ready === 1'b0) obs_rdy_low++;
            if (hold) begin
                req_cmd   = 3'($urandom_range(0, 7));
                req_wdata = 8'($urandom_range(0, 255));
            end
            obs_len++;
            @(negedge clk);
        end
        obs_rdy_end   = req_ready;
        obs_rdata_end = rsp_rdata;
        exp_f = sb_q.pop_front();
        if (cmd == CMD_RCV) begin
            for (int k = 0; k < 8; k++) slave_reg[7 - k] = obs_out[6 + k];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({req_ready, busy, rsp_valid, rsp_rdata, ser_out, ser_oe} !== 13'b0_0_0_00000000_0_1) begin
            tests_failed++;
            $display("FAIL reset_values: got rdy=%b busy=%b rv=%b rd=%h so=%b oe=%b, expected 0 0 0 00 0 1",
                     req_ready, busy, rsp_valid, rsp_rdata, ser_out, ser_oe);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_after_reset: got rdy=%b busy=%b, expected 1 0", req_ready, busy);
        end
    endtask

    task automatic test_cmd_only();
        run_frame(CMD_RST, 8'h00, 1'b0);
        tests_run++;
        if (obs_len !== 9 || obs_len !== exp_f.len) begin
            tests_failed++; $display("FAIL cmd_only_len: got %0d expected 9", obs_len);
        end
        tests_run++;
        if (obs_out !== 64'h00F || obs_out !== exp_f.out) begin
            tests_failed++; $display("FAIL cmd_only_out: got %h expected %h", obs_out, exp_f.out);
        end
        tests_run++;
        if (obs_oe !== exp_f.oe) begin
            tests_failed++; $display("FAIL cmd_only_oe: got %h expected %h", obs_oe, exp_f.oe);
        end
        tests_run++;
        if (obs_rsp_cnt !== 0) begin
            tests_failed++; $display("FAIL cmd_only_rsp: got %0d pulses expected 0", obs_rsp_cnt);
        end
    endtask

    task automatic test_rcv();
        run_frame(CMD_RCV, 8'hA5, 1'b0);
        tests_run++;
        if (obs_out !== 64'h2949 || obs_out !== exp_f.out) begin
            tests_failed++; $display("FAIL rcv_out: got %h expected %h", obs_out, exp_f.out);
        end
        tests_run++;
        if (obs_len !== 19 || obs_rdy_low !== 19 || obs_rdy_end !== 1'b1) begin
            tests_failed++;
            $display("FAIL rcv_ready: got len=%0d low=%0d end=%b expected 19 19 1", obs_len, obs_rdy_low, obs_rdy_end);
        end
        tests_run++;
        if (obs_oe !== exp_f.oe || obs_rsp_cnt !== 0) begin
            tests_failed++; $display("FAIL rcv_oe_rsp: got oe=%h rsp=%0d expected %h 0", obs_oe, obs_rsp_cnt, exp_f.oe);
        end
    endtask

    task automatic test_snd();
        slave_reg = 8'h3C;
        run_frame(CMD_SND, 8'h00, 1'b0);
        tests_run++;
        if (obs_oe_low !== 10 || obs_oe_first !== 7 || obs_oe !== exp_f.oe) begin
            tests_failed++;
            $display("FAIL snd_oe: got low=%0d first=%0d oe=%h expected 10 7 %h", obs_oe_low, obs_oe_first, obs_oe, exp_f.oe);
        end
        tests_run++;
        if (obs_rsp_cnt !== 1 || obs_rsp_cyc !== 16 || obs_rsp_cyc !== exp_f.rsp_cyc) begin
            tests_failed++; $display("FAIL snd_rsp_timing: got cnt=%0d cyc=%0d expected 1 16", obs_rsp_cnt, obs_rsp_cyc);
        end
        tests_run++;
        if (obs_rdata !== 8'h3C || obs_rdata !== exp_f.rdata) begin
            tests_failed++; $display("FAIL snd_rdata: got %h expected 3c", obs_rdata);
        end
        tests_run++;
        if (obs_len !== 21 || obs_out !== exp_f.out || obs_z_bad !== 0) begin
            tests_failed++;
            $display("FAIL snd_frame: got len=%0d out=%h zbad=%0d expected 21 %h 0", obs_len, obs_out, obs_z_bad, exp_f.out);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] prev;
        logic [7:0] jv;
        prev = 8'h3C;
        for (int j = 0; j < 256; j++) begin
            jv = 8'(j);
            run_frame(CMD_RCV, jv, 1'b0);
            tests_run++;
            if (obs_out !== exp_f.out || obs_rsp_cnt !== 0 || obs_rdata_end !== prev) begin
                tests_failed++;
                $display("FAIL loop_rcv j=%0d: got out=%h rsp=%0d rd=%h expected %h 0 %h", j, obs_out, obs_rsp_cnt, obs_rdata_end, exp_f.out, prev);
            end
            run_frame(CMD_UPD, 8'h00, 1'b0);
            run_frame(CMD_SND, 8'h00, 1'b0);
            tests_run++;
            if (obs_rsp_cnt !== 1 || obs_rdata !== jv || obs_rdata_end !== jv) begin
                tests_failed++;
                $display("FAIL loop_snd j=%0d: got rsp=%0d rd=%h hold=%h expected 1 %h", j, obs_rsp_cnt, obs_rdata, obs_rdata_end, jv);
            end
            prev = jv;
        end
    endtask

    task automatic test_rst_mid();
        int n;
        int pulses;
        slave_reg = 8'hFF;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_cmd = CMD_SND; req_wdata = 8'h00;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        pulses = 0;
        repeat (12) begin
            if (rsp_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        tests_run++;
        if (ser_oe !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_in_sample: got oe=%b expected 0", ser_oe);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ser_oe !== 1'b1 || ser_out !== 1'b0 || busy !== 1'b0 || rsp_rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got oe=%b so=%b busy=%b rd=%h expected 1 0 0 00", ser_oe, ser_out, busy, rsp_rdata);
        end
        rst = 1'b0;
        repeat (25) begin
            if (rsp_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        tests_run++;
        if (pulses !== 0 || rsp_rdata !== 8'h00 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_no_rsp: got pulses=%0d rd=%h busy=%b expected 0 00 0", pulses, rsp_rdata, busy);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(CMD_RCV, 8'h5A, 1'b1);
        tests_run++;
        if (obs_rdy_low !== obs_len || obs_len !== 19 || obs_out !== exp_f.out) begin
            tests_failed++;
            $display("FAIL b2b_first: got len=%0d low=%0d out=%h expected 19 19 %h", obs_len, obs_rdy_low, obs_out, exp_f.out);
        end
        run_frame(CMD_RST, 8'h00, 1'b0);
        tests_run++;
        if (obs_len !== 9 || obs_out !== exp_f.out || obs_out !== 64'h00F) begin
            tests_failed++;
            $display("FAIL b2b_second: got len=%0d out=%h expected 9 %h", obs_len, obs_out, exp_f.out);
        end
    endtask

    initial begin
        test_reset();
        test_cmd_only();
        test_rcv();
        test_snd();
        test_loopback();
        test_rst_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
